// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lsu
// Brief    : Load/store unit driving a word-addressed data memory port.
//            Byte-addressed loads/stores with sign/zero extension; sub-word
//            stores are done as read-modify-write because the memory has no
//            byte enables.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = 32,
   localparam int MEM_AW    = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  RESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   output logic                  mem_write,
   output logic                  mem_read,
   input  logic [DATA_WIDTH-1:0] mem_dout
);

   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ERR     = 3'd1,
      LD      = 3'd2,
      LD_DATA = 3'd3,
      ST      = 3'd4,
      RMW_RD  = 3'd5,
      RMW_WR  = 3'd6,
      RESP    = 3'd7
   } state_t;

   state_t                  r_state;
   logic [1:0]              r_size;
   logic                    r_unsigned;
   logic [1:0]              r_lane;
   logic [DATA_WIDTH-1:0]   r_wdata;

   logic [ADDR_WIDTH-1:0]   w_word_idx;
   logic                    w_req_err;
   logic [7:0]              w_byte;
   logic [15:0]             w_half;
   logic [DATA_WIDTH-1:0]   w_load;
   logic [DATA_WIDTH-1:0]   w_merge;

   assign req_ready  = (r_state == IDLE);
   assign w_word_idx = req_addr >> 2;

   // Classify the incoming request as illegal before it is accepted
   always_comb begin
      w_req_err = 1'b0;
      if (req_size == 2'b11)                                  w_req_err = 1'b1;
      if (req_size == c_size_half && req_addr[0])             w_req_err = 1'b1;
      if (req_size == c_size_word && req_addr[1:0] != 2'b00)  w_req_err = 1'b1;
      if (w_word_idx >= ADDR_WIDTH'(MEM_DEPTH))               w_req_err = 1'b1;
   end

   // Pick the addressed lane from the read word and extend it
   always_comb begin
      w_byte = mem_dout[{r_lane, 3'b000} +: 8];
      w_half = mem_dout[{r_lane[1], 4'b0000} +: 16];
      case (r_size)
         c_size_byte: w_load = r_unsigned ? {{(DATA_WIDTH-8){1'b0}}, w_byte}
                                          : {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
         c_size_half: w_load = r_unsigned ? {{(DATA_WIDTH-16){1'b0}}, w_half}
                                          : {{(DATA_WIDTH-16){w_half[15]}}, w_half};
         default:     w_load = mem_dout;
      endcase
   end

   // Splice the store lane into the word just read back from memory
   always_comb begin
      w_merge = mem_dout;
      if (r_size == c_size_byte) w_merge[{r_lane, 3'b000} +: 8]     = r_wdata[7:0];
      else                       w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   // Write data is the merged word during RMW, the raw store data otherwise
   assign mem_write_data = !mem_write          ? '0      :
                           (r_state == RMW_WR) ? w_merge : r_wdata;

   // Sequencer: latches the request and drives registered port strobes
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_state    <= IDLE;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_lane     <= 2'b00;
         r_wdata    <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_addr   <= '0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_size     <= req_size;
                  r_unsigned <= req_unsigned;
                  r_lane     <= req_addr[1:0];
                  r_wdata    <= req_wdata;
                  mem_addr   <= w_word_idx[MEM_AW-1:0];
                  if (w_req_err) begin
                     r_state    <= ERR;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (!req_we) begin
                     r_state  <= LD;
                     mem_read <= 1'b1;
                  end else if (req_size == c_size_word) begin
                     r_state   <= ST;
                     mem_write <= 1'b1;
                  end else begin
                     r_state  <= RMW_RD;
                     mem_read <= 1'b1;
                  end
               end
            end
            LD: begin
               mem_read <= 1'b0;
               r_state  <= LD_DATA;
            end
            LD_DATA: begin
               resp_rdata <= w_load;
               resp_valid <= 1'b1;
               r_state    <= RESP;
            end
            ST: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               r_state    <= RESP;
            end
            RMW_RD: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b1;
               r_state   <= RMW_WR;
            end
            RMW_WR: begin
               mem_write  <= 1'b0;
               resp_valid <= 1'b1;
               r_state    <= RESP;
            end
            default: begin
               // RESP and ERR: single response cycle, then back to idle
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               mem_addr   <= '0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_lsu
// Brief    : Randomized self-checking bench for dmem_lsu against a byte-array
//            memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int AW    = 32;
   localparam int MAW   = 10;

   logic           clk = 1'b0;
   logic           RESET;
   logic           req_valid;
   logic           req_ready;
   logic           req_we;
   logic [1:0]     req_size;
   logic           req_unsigned;
   logic [AW-1:0]  req_addr;
   logic [DW-1:0]  req_wdata;
   logic           resp_valid;
   logic [DW-1:0]  resp_rdata;
   logic           resp_err;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_write_data;
   logic           mem_write;
   logic           mem_read;
   logic [DW-1:0]  mem_dout = '0;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   dmem_lsu #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .RESET(RESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_write(mem_write), .mem_read(mem_read), .mem_dout(mem_dout)
   );

   // Data memory: registered read, unwritten words read as all ones
   logic [31:0] mem [int];
   always @(posedge clk) begin
      if (mem_read)  mem_dout <= mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'hFFFF_FFFF;
      if (mem_write) mem[int'(mem_addr)] = mem_write_data;
   end

   // Reference contents kept as plain bytes
   logic [7:0] ref_mem [4096];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int size_bytes(input logic [1:0] size);
      return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns, input logic [31:0] addr);
      int n = size_bytes(size);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(addr[11:0]) + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] idx);
      logic [31:0] v = '0;
      for (int i = 0; i < 4; i++) v = v | (32'(ref_mem[int'(idx[9:0]) * 4 + i]) << (8 * i));
      return v;
   endfunction

   task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      for (int i = 0; i < size_bytes(size); i++) ref_mem[int'(addr[11:0]) + i] = wdata[8*i +: 8];
   endtask

   // One complete transaction with cycle-by-cycle port checks
   task automatic run_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit b2b);
      int          lat;
      int          nwait;
      bit          rdy;
      bit          err;
      bit          sub;
      logic [31:0] idx;
      logic [31:0] exp_rd;
      logic [31:0] exp_wr;
      bit          exp_mr;
      bit          exp_mw;
      idx    = addr >> 2;
      err    = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
               (size == 2'd2 && addr[1:0] != 2'd0) || (idx >= 32'(DEPTH));
      sub    = (size != 2'd2);
      exp_rd = '0;
      exp_wr = '0;
      if (!err && !we) exp_rd = ref_load(size, uns, addr);
      if (!err && we) begin
         ref_store(size, addr, wdata);
         exp_wr = ref_word(idx);
      end
      lat = err ? 1 : (we && !sub) ? 2 : 3;

      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr;  req_wdata = wdata;
      nwait = 0;
      rdy   = 1'b0;
      while (!rdy) begin
         rdy = req_ready;
         @(posedge clk); #1;
         if (!rdy) nwait++;
         if (nwait > 20) begin
            check("accept_timeout", 32'(nwait), 32'd0);
            req_valid = 1'b0;
            return;
         end
      end
      if (b2b) check("b2b_gap", 32'(nwait), 32'd1);

      // Fields are free to change once accepted
      req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;

      for (int c = 1; c <= lat; c++) begin
         exp_mr = !err && (c == 1) && !(we && !sub);
         exp_mw = !err && we && (sub ? (c == 2) : (c == 1));
         check("req_ready_busy", 32'(req_ready), 32'd0);
         check("resp_valid",     32'(resp_valid), 32'(c == lat));
         check("mem_read",       32'(mem_read), 32'(exp_mr));
         check("mem_write",      32'(mem_write), 32'(exp_mw));
         if (!err) check("mem_addr", 32'(mem_addr), 32'(idx[9:0]));
         check("mem_write_data", mem_write_data, exp_mw ? exp_wr : 32'd0);
         check("resp_err",       32'(resp_err), (c == lat) ? 32'(err) : 32'd0);
         check("resp_rdata",     resp_rdata, (c == lat) ? exp_rd : 32'd0);
         if (c < lat) begin @(posedge clk); #1; end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ready"},  32'(req_ready), 32'd1);
      check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
      check({tag, "_rdata"},  resp_rdata, 32'd0);
      check({tag, "_rerr"},   32'(resp_err), 32'd0);
      check({tag, "_mread"},  32'(mem_read), 32'd0);
      check({tag, "_mwrite"}, 32'(mem_write), 32'd0);
      check({tag, "_maddr"},  32'(mem_addr), 32'd0);
      check({tag, "_mwdata"}, mem_write_data, 32'd0);
   endtask

   // Read and write strobes must never coincide
   always @(negedge clk) begin
      if (RESET) check("rw_overlap", 32'(mem_read && mem_write), 32'd0);
   end

   initial begin
      logic [1:0]  sz;
      int          r;
      logic [31:0] a;
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'hFF;
      RESET = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 check_idle_outputs("in_reset");
      @(negedge clk) RESET = 1'b1;
      @(posedge clk); #1 check_idle_outputs("post_reset");

      run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
      run_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b1);
      run_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0, 1'b1);
      run_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b1);
      run_req(1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 1'b1);
      run_req(1'b1, 2'd0, 1'b0, 32'h22, 32'hFFFF_FFAB, 1'b1);
      run_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0, 1'b1);
      run_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 1'b1);
      run_req(1'b0, 2'd2, 1'b0, 32'h21, 32'h0, 1'b1);
      run_req(1'b1, 2'd1, 1'b0, 32'h33, 32'hDEAD_BEEF, 1'b1);
      run_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 1'b1);
      run_req(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b1);

      // Abort a byte store during its read phase
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h41; req_wdata = 32'hCD;
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("rst_rmw_read", 32'(mem_read), 32'd1);
      #2 RESET = 1'b0;
      #1 check_idle_outputs("async_reset");
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("rst_no_write", 32'(mem_write), 32'd0);
         check("rst_no_resp",  32'(resp_valid), 32'd0);
      end
      @(negedge clk) RESET = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         check("rst_rel_ready", 32'(req_ready), 32'd1);
         check("rst_rel_write", 32'(mem_write), 32'd0);
         check("rst_rel_resp",  32'(resp_valid), 32'd0);
      end
      run_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 1'b0);

      for (int n = 0; n < 300; n++) begin
         r  = int'($urandom_range(0, 7));
         sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
         a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4200));
         run_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
      end

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that acts as the requesting side of the data memory port. It accepts byte-addressed load and store requests from the core over a valid/ready handshake. It drives the word-addressed dmem port (addr, write_data, mem_write, mem_read) and returns extracted, sign- or zero-extended load data. The memory has no byte enables, so sub-word stores are performed as a read-modify-write.

## Interface
- DATA_WIDTH, 32, data word width; only 32 is supported.
- MEM_DEPTH, 1024, number of memory words.
- ADDR_WIDTH, 32, width of the core byte address.

- clk  in  1  clock
- RESET  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  LSU can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- req_unsigned  in  1  zero-extend load data (loads only)
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  load result; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or reserved-size request
- mem_addr  out  $clog2(MEM_DEPTH)  word index to dmem
- mem_write_data  out  DATA_WIDTH  write data to dmem
- mem_write  out  1  dmem write strobe
- mem_read  out  1  dmem read strobe
- mem_dout  in  DATA_WIDTH  dmem registered read data

## Operation
- States: IDLE, ERR, LD, LD_DATA, ST, RMW_RD, RMW_WR, RESP.
- req_ready = (state == IDLE). A request is accepted on the clk edge where req_valid && req_ready. All request fields are latched at that edge.
- Word index = req_addr[ADDR_WIDTH-1:2]. Byte lane = addr[1:0], little-endian. Halfword lane = addr[1].
- Error check at accept. Any of the following sends IDLE→ERR, which raises resp_err=1 and never touches memory:
  - req_size == 11
  - half with addr[0] = 1
  - word with addr[1:0] ≠ 0
  - word index ≥ MEM_DEPTH
- Load path: IDLE→LD→LD_DATA→RESP.
  - LD: mem_read=1, mem_addr=index.
  - LD_DATA: select the lane from mem_dout, extend per req_unsigned, register into resp_rdata.
- Word store path: IDLE→ST→RESP.
  - ST: mem_write=1, mem_write_data=req_wdata.
- Sub-word store path: IDLE→RMW_RD→RMW_WR→RESP.
  - RMW_RD: mem_read=1.
  - RMW_WR: mem_write=1, mem_write_data = mem_dout with the target lane replaced by req_wdata[7:0] or req_wdata[15:0].
- RESP and ERR each last one cycle with resp_valid=1, then return to IDLE.
- mem_read and mem_write are never high in the same cycle.
- mem_addr holds the latched index in every non-IDLE state and is 0 in IDLE. mem_write_data is 0 when mem_write=0.
- Unused inputs (req_wdata on loads, req_unsigned on stores) are ignored.

## Timing
- Cycle 0 is the cycle in which the request is accepted.
- Load: mem_read high in cycle 1, mem_dout valid in cycle 2, resp_valid in cycle 3.
- Word store: mem_write in cycle 1, resp_valid in cycle 2. The write is committed before the response.
- Sub-word store: mem_read in cycle 1, mem_write in cycle 2, resp_valid in cycle 3.
- Error: resp_valid with resp_err=1 in cycle 1.
- req_ready is low from cycle 1 through the resp_valid cycle. The next request can be accepted in the cycle after resp_valid.
- resp_rdata and resp_err are valid only while resp_valid=1, and are 0 otherwise.
- Reset values:
  - state = IDLE, so req_ready = 1.
  - resp_valid, resp_rdata, resp_err = 0.
  - mem_read, mem_write, mem_addr, mem_write_data = 0.
- RESET asserted mid-operation:
  - Takes effect immediately and aborts the operation.
  - No response is issued.
  - If RESET is asserted in RMW_RD, no mem_write occurs for that request.
- Request fields may change after acceptance without effect.

## Test plan
- Load word after reset, addr 0x10, memory at its reset content → resp_rdata = 0xFFFFFFFF in cycle 3, resp_err = 0, mem_read high only in cycle 1 with mem_addr = 4.
- Store word 0x12345678 @0x20 (resp in cycle 2), then:
  - signed byte load @0x23 → 0x00000012
  - unsigned byte load @0x21 → 0x00000056
  - signed half load @0x20 → 0x00005678
- Store byte 0xAB @0x22 over that word:
  - mem_read in cycle 1, then mem_write_data = 0x12AB5678 in cycle 2, resp in cycle 3.
  - Signed byte load @0x22 → 0xFFFFFFAB.
  - Unsigned half load @0x22 → 0x000012AB.
- Each of the following → resp_err = 1 in cycle 1, resp_rdata = 0, and mem_read/mem_write never asserted:
  - word load @0x21
  - half store @0x33
  - req_size = 11
  - word load @0x1000 with MEM_DEPTH = 1024
- req_valid held high across two loads → second accept occurs exactly one cycle after the first resp_valid. req_ready is 0 in cycles 1–3 and mem_read/mem_write never overlap.
- RESET pulsed low during RMW_RD of a byte store → all outputs return to reset values immediately, no mem_write and no resp_valid for that request, req_ready = 1 after release.
